// File: rtl/alarm_requester.sv
// Alarm requester: decides when the buzzer should sound for a programmed alarm.
// Runs an IDLE / RING / SNOOZE state machine and counts seconds in RING and SNOOZE.
// The snooze and stop buttons are synchronised and edge-detected before use.
// Optional build macro ALARM_AUTO_SNOOZE_EN: when defined, a RING timeout acts
// like a snooze press. When undefined, a RING timeout returns to IDLE.
`timescale 1ns/1ps
module alarm_requester #(
  parameter int ring_secs       = 60,
  parameter int ring_secs_log   = 6,
  parameter int snooze_secs     = 300,
  parameter int snooze_secs_log = 9,
  parameter int max_snooze      = 3
) (
  input  logic       clk,
  input  logic       _rst,
  input  logic       sec_tick,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic [4:0] alm_hour,
  input  logic [5:0] alm_min,
  input  logic       alarm_en,
  input  logic       btn_snooze,
  input  logic       btn_stop,
  output logic       beep_req,
  output logic       ringing,
  output logic       snoozing,
  output logic [1:0] snooze_cnt
);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_e;

`ifdef ALARM_AUTO_SNOOZE_EN
  localparam bit AUTO_SNOOZE = 1'b1;
`else
  localparam bit AUTO_SNOOZE = 1'b0;
`endif

  localparam logic [ring_secs_log-1:0]   RING_LAST = ring_secs_log'(ring_secs - 1);
  localparam logic [snooze_secs_log-1:0] SNZ_LAST  = snooze_secs_log'(snooze_secs - 1);
  localparam logic [1:0]                 SNZ_MAX   = 2'(max_snooze);

  logic [1:0] snz_sync_q, stp_sync_q;
  logic       snz_prev_q, stp_prev_q;
  logic [2:0] rdy_q, rdy_d;
  logic       snz_press, stp_press, match, ring_to, snz_to;

  state_e                     state_q;
  logic [ring_secs_log-1:0]   ring_cnt_q;
  logic [snooze_secs_log-1:0] snz_sec_q;
  logic [1:0]                 snooze_cnt_q;
  logic                       beep_q, ringing_q, snoozing_q;

  // rdy_q fills with ones after reset so that a button held through reset
  // does not produce an edge while the synchronisers are filling.
  assign rdy_d     = {rdy_q[1:0], 1'b1};
  assign snz_press = snz_sync_q[1] & ~snz_prev_q & rdy_q[2];
  assign stp_press = stp_sync_q[1] & ~stp_prev_q & rdy_q[2];
  assign match     = alarm_en & sec_tick & (cur_hour == alm_hour) &
                     (cur_min == alm_min) & (cur_sec == 6'd0);
  assign ring_to   = sec_tick & (ring_cnt_q == RING_LAST);
  assign snz_to    = sec_tick & (snz_sec_q == SNZ_LAST);

  // Two-flop synchronisers plus previous-value flops for rising-edge detection.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      snz_sync_q <= '0;
      stp_sync_q <= '0;
      snz_prev_q <= 1'b0;
      stp_prev_q <= 1'b0;
      rdy_q      <= '0;
    end else begin
      snz_sync_q <= {snz_sync_q[0], btn_snooze};
      stp_sync_q <= {stp_sync_q[0], btn_stop};
      snz_prev_q <= snz_sync_q[1];
      stp_prev_q <= stp_sync_q[1];
      rdy_q      <= rdy_d;
    end
  end

  // Alarm state machine.
  // Priority order: disable first, then stop, then snooze, then second timeouts.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state_q      <= IDLE;
      ring_cnt_q   <= '0;
      snz_sec_q    <= '0;
      snooze_cnt_q <= '0;
      beep_q       <= 1'b0;
      ringing_q    <= 1'b0;
      snoozing_q   <= 1'b0;
    end else if (!alarm_en) begin
      state_q      <= IDLE;
      ring_cnt_q   <= '0;
      snz_sec_q    <= '0;
      snooze_cnt_q <= '0;
      beep_q       <= 1'b0;
      ringing_q    <= 1'b0;
      snoozing_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (match) begin
            state_q      <= RING;
            ring_cnt_q   <= '0;
            snooze_cnt_q <= '0;
            beep_q       <= 1'b1;
            ringing_q    <= 1'b1;
            snoozing_q   <= 1'b0;
          end
        end
        RING: begin
          if (!stp_press && (snz_press || (AUTO_SNOOZE && ring_to)) &&
              (snooze_cnt_q < SNZ_MAX)) begin
            state_q      <= SNOOZE;
            snz_sec_q    <= '0;
            snooze_cnt_q <= snooze_cnt_q + 2'd1;
            beep_q       <= 1'b0;
            ringing_q    <= 1'b0;
            snoozing_q   <= 1'b1;
          end else if (stp_press || snz_press || ring_to) begin
            // Stop, a snooze press once all snoozes are used, or a timeout
            // that does not snooze: each of these ends the alarm event.
            state_q      <= IDLE;
            ring_cnt_q   <= '0;
            snooze_cnt_q <= '0;
            beep_q       <= 1'b0;
            ringing_q    <= 1'b0;
            snoozing_q   <= 1'b0;
          end else if (sec_tick) begin
            ring_cnt_q <= ring_cnt_q + 1'b1;
          end
        end
        SNOOZE: begin
          if (stp_press) begin
            state_q      <= IDLE;
            snz_sec_q    <= '0;
            snooze_cnt_q <= '0;
            beep_q       <= 1'b0;
            ringing_q    <= 1'b0;
            snoozing_q   <= 1'b0;
          end else if (snz_to) begin
            state_q    <= RING;
            ring_cnt_q <= '0;
            beep_q     <= 1'b1;
            ringing_q  <= 1'b1;
            snoozing_q <= 1'b0;
          end else if (sec_tick) begin
            snz_sec_q <= snz_sec_q + 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          beep_q     <= 1'b0;
          ringing_q  <= 1'b0;
          snoozing_q <= 1'b0;
        end
      endcase
    end
  end

  assign beep_req   = beep_q;
  assign ringing    = ringing_q;
  assign snoozing   = snoozing_q;
  assign snooze_cnt = snooze_cnt_q;

endmodule

// File: doc/alarm_requester.md
ALARM_REQUESTER -- requirements
Module: alarm_requester

Interface
REQ-001 SHALL have parameter ring_secs, default 60: seconds RING lasts before timeout.
REQ-002 SHALL have parameter ring_secs_log, default 6: width of ring second counter.
REQ-003 SHALL have parameter snooze_secs, default 300: seconds spent in SNOOZE before re-ring.
REQ-004 SHALL have parameter snooze_secs_log, default 9: width of snooze second counter.
REQ-005 SHALL have parameter max_snooze, default 3: snoozes allowed per alarm event.
REQ-006 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-007 SHALL have port _rst  input  1  reset; asynchronous, active-low.
REQ-008 SHALL have port sec_tick  input  1  one-cycle pulse per second from clock core.
REQ-009 SHALL have ports cur_hour/cur_min/cur_sec  input  5/6/6  current time, binary.
REQ-010 SHALL have ports alm_hour/alm_min  input  5/6  programmed alarm time, binary.
REQ-011 SHALL have port alarm_en  input  1  alarm armed when 1.
REQ-012 SHALL have ports btn_snooze/btn_stop  input  1 each  raw active-high buttons, asynchronous to clk.
REQ-013 SHALL have port beep_req  output  1  level request to buzzer block's in_button input.
REQ-014 SHALL have ports ringing/snoozing  output  1 each  state indicators.
REQ-015 SHALL have port snooze_cnt  output  2  snoozes used in current alarm event.

Function
REQ-016 SHALL implement FSM states IDLE, RING, SNOOZE; all outputs registered.
REQ-017 SHALL pass each button through 2-flop synchronizer then rising-edge detector; press acts on 3rd rising clk edge after button rises.
REQ-018 SHALL define match = alarm_en & sec_tick & cur_hour==alm_hour & cur_min==alm_min & cur_sec==0.
REQ-019 SHALL move IDLE->RING on match; beep_req, ringing high from the next cycle; snooze_cnt cleared.
REQ-020 SHALL ignore match while in RING or SNOOZE.
REQ-021 SHALL in RING count sec_tick pulses from 0; counter cleared on every entry to RING and SNOOZE.
REQ-022 SHALL in RING on snooze press with snooze_cnt<max_snooze go to SNOOZE, snooze_cnt+1, beep_req 0, snoozing 1.
REQ-023 SHALL treat snooze press with snooze_cnt==max_snooze as stop.
REQ-024 SHALL on stop press in RING or SNOOZE go to IDLE, clearing snooze_cnt, beep_req, ringing, snoozing.
REQ-025 SHALL in SNOOZE, on the sec_tick making the count equal snooze_secs, go to RING.
REQ-026 SHALL give priority: alarm_en==0 > stop > snooze > sec_tick timeout; alarm_en low forces IDLE next cycle from any state.
REQ-027 SHALL ignore snooze press in IDLE and SNOOZE.
REQ-028 SHALL saturate snooze_cnt at max_snooze, never wrap.

Reset
REQ-029 SHALL on _rst low immediately force IDLE, beep_req 0, ringing 0, snoozing 0, snooze_cnt 0, counters 0, synchronizer/edge flops 0.
REQ-030 SHALL resume from IDLE on _rst release; no spurious press from a button held during reset.
REQ-031 SHALL abort RING/SNOOZE mid-operation on reset with no pending re-ring.

Configuration
REQ-032 SHALL support macro ALARM_AUTO_SNOOZE_EN.
REQ-033 SHALL with ALARM_AUTO_SNOOZE_EN defined, on RING timeout (count==ring_secs) act as a snooze press (REQ-022/023).
REQ-034 SHALL without ALARM_AUTO_SNOOZE_EN, on RING timeout go to IDLE and clear snooze_cnt.

Verification (ring_secs=4, snooze_secs=3, max_snooze=2, sec_tick every 10 clk)
REQ-035 SHALL cover: alm 07:30, time 07:30:00 with sec_tick, alarm_en=1 -> beep_req=1, ringing=1 next cycle; same at 07:30:01 -> no ring.
REQ-036 SHALL cover: RING, btn_snooze pulse 5 clk -> snoozing=1, snooze_cnt=1, beep_req=0; 3 sec_ticks later -> beep_req=1.
REQ-037 SHALL cover: snooze twice, third snooze press -> IDLE, snooze_cnt=0, all outputs 0.
REQ-038 SHALL cover: btn_stop and btn_snooze rise same cycle in RING -> IDLE, snooze_cnt=0.
REQ-039 SHALL cover: RING untouched 4 sec_ticks -> with macro SNOOZE, snooze_cnt=1; without macro IDLE.
REQ-040 SHALL cover: _rst low mid-SNOOZE with btn_snooze held -> outputs 0 asynchronously; after release no state change until a new button edge or match.
